// File: rtl/bp_gshare_predict.sv
// Gshare branch predictor: pre-decodes B-type/JAL, indexes 2-bit counters with PC XOR
// global history, and registers the next-PC prediction with a history checkpoint.
module bp_gshare_predict #(
    parameter int         INDEX_BITS = 6,
    parameter int         GHR_BITS   = 6,
    parameter logic [1:0] CTR_INIT   = 2'b01
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  pred_valid_in,
    input  logic [31:0]           pc_in,
    input  logic [31:0]           instruction_in,
    output logic                  pred_valid_out,
    output logic                  pred_cond_out,
    output logic                  pred_taken_out,
    output logic [31:0]           pred_target_out,
    output logic [INDEX_BITS-1:0] pred_index_out,
    output logic [GHR_BITS-1:0]   pred_ghr_out,
    input  logic                  upd_valid_in,
    input  logic [INDEX_BITS-1:0] upd_index_in,
    input  logic                  upd_taken_in,
    input  logic                  upd_mispredict_in,
    input  logic [GHR_BITS-1:0]   upd_ghr_in
);

    localparam int DEPTH = 1 << INDEX_BITS;

    logic [1:0]            ctr_reg  [DEPTH];
    logic [1:0]            ctr_next [DEPTH];
    logic [GHR_BITS-1:0]   ghr_reg;
    logic [GHR_BITS-1:0]   ghr_next;

    logic                  valid_reg;
    logic                  cond_reg;
    logic                  taken_reg;
    logic [31:0]           target_reg;
    logic [INDEX_BITS-1:0] index_reg;
    logic [GHR_BITS-1:0]   ghr_ckpt_reg;

    // Pre-decode
    logic [6:0]            opcode;
    logic                  is_branch;
    logic                  is_jal;
    logic [31:0]           b_imm;
    logic [31:0]           j_imm;
    logic [INDEX_BITS-1:0] ghr_ext;
    logic [INDEX_BITS-1:0] index;
    logic [1:0]            rd_ctr;
    logic                  taken;
    logic [31:0]           target;
    logic [GHR_BITS-1:0]   ghr_spec;
    logic [GHR_BITS-1:0]   ghr_recover;
    logic [1:0]            upd_cur;
    logic [1:0]            upd_sat;
    logic                  unused_ghr_msb;

    assign opcode    = instruction_in[6:0];
    assign is_branch = (opcode == 7'b1100011);
    assign is_jal    = (opcode == 7'b1101111);

    assign b_imm = {{19{instruction_in[31]}}, instruction_in[31], instruction_in[7],
                    instruction_in[30:25], instruction_in[11:8], 1'b0};
    assign j_imm = {{11{instruction_in[31]}}, instruction_in[31], instruction_in[19:12],
                    instruction_in[20], instruction_in[30:21], 1'b0};

    generate
        if (GHR_BITS == INDEX_BITS) begin : g_ghr_full
            assign ghr_ext = ghr_reg;
        end else begin : g_ghr_pad
            assign ghr_ext = {{(INDEX_BITS-GHR_BITS){1'b0}}, ghr_reg};
        end

        // A one-bit history simply holds the latest outcome
        if (GHR_BITS == 1) begin : g_hist1
            assign ghr_spec    = taken;
            assign ghr_recover = upd_taken_in;
        end else begin : g_histn
            assign ghr_spec    = {ghr_reg[GHR_BITS-2:0], taken};
            assign ghr_recover = {upd_ghr_in[GHR_BITS-2:0], upd_taken_in};
        end
    endgenerate

    // The checkpoint's oldest bit falls off the end during recovery
    assign unused_ghr_msb = upd_ghr_in[GHR_BITS-1];

    assign index  = pc_in[INDEX_BITS+1:2] ^ ghr_ext;
    assign rd_ctr = ctr_reg[index];

    always_comb begin
        taken  = 1'b0;
        target = pc_in + 32'd4;
        if (is_branch) begin
            taken = rd_ctr[1];
            if (rd_ctr[1]) begin
                target = pc_in + b_imm;
            end
        end else if (is_jal) begin
            taken  = 1'b1;
            target = pc_in + j_imm;
        end
    end

    // Recovery wins over the speculative shift of a same-cycle prediction
    always_comb begin
        ghr_next = ghr_reg;
        if (pred_valid_in && is_branch) begin
            ghr_next = ghr_spec;
        end
        if (upd_valid_in && upd_mispredict_in) begin
            ghr_next = ghr_recover;
        end
    end

    assign upd_cur = ctr_reg[upd_index_in];

    always_comb begin
        upd_sat = upd_cur;
        if (upd_taken_in) begin
            if (upd_cur != 2'b11) begin
                upd_sat = upd_cur + 2'b01;
            end
        end else if (upd_cur != 2'b00) begin
            upd_sat = upd_cur - 2'b01;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_ctr
            assign ctr_next[gi] = (upd_valid_in && (upd_index_in == INDEX_BITS'(gi)))
                                  ? upd_sat : ctr_reg[gi];
        end
    endgenerate

    // Reads above see the pre-update counters; writes land at the edge
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr_reg[i] <= CTR_INIT;
            end
            ghr_reg <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr_reg[i] <= ctr_next[i];
            end
            ghr_reg <= ghr_next;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid_reg    <= 1'b0;
            cond_reg     <= 1'b0;
            taken_reg    <= 1'b0;
            target_reg   <= '0;
            index_reg    <= '0;
            ghr_ckpt_reg <= '0;
        end else begin
            valid_reg    <= pred_valid_in;
            cond_reg     <= pred_valid_in & is_branch;
            taken_reg    <= pred_valid_in & taken;
            target_reg   <= pred_valid_in ? target  : '0;
            index_reg    <= pred_valid_in ? index   : '0;
            ghr_ckpt_reg <= pred_valid_in ? ghr_reg : '0;
        end
    end

    assign pred_valid_out  = valid_reg;
    assign pred_cond_out   = cond_reg;
    assign pred_taken_out  = taken_reg;
    assign pred_target_out = target_reg;
    assign pred_index_out  = index_reg;
    assign pred_ghr_out    = ghr_ckpt_reg;

endmodule

// File: tb/tb_bp_gshare_predict.sv
// Directed bench for bp_gshare_predict with hand-computed expectations.
module tb_bp_gshare_predict;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        pred_valid_in;
    logic [31:0] pc_in;
    logic [31:0] instruction_in;
    logic        pred_valid_out;
    logic        pred_cond_out;
    logic        pred_taken_out;
    logic [31:0] pred_target_out;
    logic [5:0]  pred_index_out;
    logic [5:0]  pred_ghr_out;
    logic        upd_valid_in;
    logic [5:0]  upd_index_in;
    logic        upd_taken_in;
    logic        upd_mispredict_in;
    logic [5:0]  upd_ghr_in;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [31:0] ADDI = 32'h0000_0013;

    bp_gshare_predict #(.INDEX_BITS(6), .GHR_BITS(6), .CTR_INIT(2'b01)) dut (
        .clk_in            (clk_in),
        .rst_n_in          (rst_n_in),
        .pred_valid_in     (pred_valid_in),
        .pc_in             (pc_in),
        .instruction_in    (instruction_in),
        .pred_valid_out    (pred_valid_out),
        .pred_cond_out     (pred_cond_out),
        .pred_taken_out    (pred_taken_out),
        .pred_target_out   (pred_target_out),
        .pred_index_out    (pred_index_out),
        .pred_ghr_out      (pred_ghr_out),
        .upd_valid_in      (upd_valid_in),
        .upd_index_in      (upd_index_in),
        .upd_taken_in      (upd_taken_in),
        .upd_mispredict_in (upd_mispredict_in),
        .upd_ghr_in        (upd_ghr_in)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [31:0] b_enc(input int imm, input logic [2:0] f3);
        logic [12:0] i;
        i = imm[12:0];
        return {i[12], i[10:5], 5'd2, 5'd1, f3, i[4:1], i[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] j_enc(input int imm);
        logic [20:0] i;
        i = imm[20:0];
        return {i[20], i[10:1], i[11], i[19:12], 5'd1, 7'b1101111};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-14s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_pred(input string tag, input logic v, input logic c, input logic t,
                              input logic [31:0] tgt, input logic [5:0] idx,
                              input logic [5:0] ghr);
        chk({tag, ".valid"},  pred_valid_out,  v);
        chk({tag, ".cond"},   pred_cond_out,   c);
        chk({tag, ".taken"},  pred_taken_out,  t);
        chk({tag, ".target"}, pred_target_out, tgt);
        chk({tag, ".index"},  pred_index_out,  idx);
        chk({tag, ".ghr"},    pred_ghr_out,    ghr);
    endtask

    task automatic clear_inputs();
        pred_valid_in     = 1'b0;
        pc_in             = '0;
        instruction_in    = '0;
        upd_valid_in      = 1'b0;
        upd_index_in      = '0;
        upd_taken_in      = 1'b0;
        upd_mispredict_in = 1'b0;
        upd_ghr_in        = '0;
    endtask

    // Advance one edge, land 1 ns after it, then drop all valid strobes
    task automatic cycle();
        @(posedge clk_in);
        #1;
        clear_inputs();
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n_in = 1'b0;
        #2;
        rst_n_in = 1'b1;
    endtask

    task automatic set_pred(input logic [31:0] pc, input logic [31:0] inst);
        pred_valid_in  = 1'b1;
        pc_in          = pc;
        instruction_in = inst;
    endtask

    task automatic set_upd(input logic [5:0] idx, input logic tk, input logic mp,
                           input logic [5:0] ghr);
        upd_valid_in      = 1'b1;
        upd_index_in      = idx;
        upd_taken_in      = tk;
        upd_mispredict_in = mp;
        upd_ghr_in        = ghr;
    endtask

    task automatic upd_n(input int n, input logic [5:0] idx, input logic tk);
        for (int k = 0; k < n; k++) begin
            set_upd(idx, tk, 1'b0, 6'd0);
            cycle();
        end
    endtask

    initial begin
        clear_inputs();
        rst_n_in = 1'b0;
        #2;
        check_pred("reset", 0, 0, 0, 32'h0, 6'd0, 6'd0);
        #1;
        rst_n_in = 1'b1;

        // BEQ +16 at 0x100, fresh counters
        set_pred(32'h100, b_enc(16, 3'b000));
        cycle();
        check_pred("beq_nt", 1, 1, 0, 32'h104, 6'd0, 6'd0);
        cycle();
        check_pred("idle", 0, 0, 0, 32'h0, 6'd0, 6'd0);

        // Two non-mispredict updates leave GHR alone
        do_reset();
        upd_n(2, 6'd5, 1'b1);
        set_pred(32'h14, b_enc(-8, 3'b001));
        cycle();
        check_pred("bne_tk", 1, 1, 1, 32'h0C, 6'd5, 6'd0);

        // Same-cycle update and prediction on one index: prediction sees the old counter
        do_reset();
        set_upd(6'd5, 1'b1, 1'b0, 6'd0);
        set_pred(32'h14, b_enc(-8, 3'b000));
        cycle();
        check_pred("rd_old", 1, 1, 0, 32'h18, 6'd5, 6'd0);
        set_pred(32'h14, b_enc(-8, 3'b000));
        cycle();
        check_pred("rd_new", 1, 1, 1, 32'h0C, 6'd5, 6'd0);

        // Saturation at both ends
        do_reset();
        upd_n(5, 6'd9, 1'b1);
        upd_n(1, 6'd9, 1'b0);
        upd_n(3, 6'd10, 1'b0);
        upd_n(1, 6'd10, 1'b1);
        set_pred(32'h28, b_enc(16, 3'b000));
        cycle();
        check_pred("sat_lo", 1, 1, 0, 32'h2C, 6'd10, 6'd0);
        set_pred(32'h24, b_enc(16, 3'b000));
        cycle();
        check_pred("sat_hi", 1, 1, 1, 32'h34, 6'd9, 6'd0);

        // JAL and non-branch with GHR forced to 000001 by a recovery
        do_reset();
        set_upd(6'd0, 1'b1, 1'b1, 6'd0);
        cycle();
        set_pred(32'h200, j_enc(-4));
        cycle();
        check_pred("jal", 1, 0, 1, 32'h1FC, 6'd1, 6'd1);
        set_pred(32'hFFFF_FFFC, j_enc(8));
        cycle();
        check_pred("jal_wrap", 1, 0, 1, 32'h4, 6'd62, 6'd1);
        set_pred(32'h300, ADDI);
        cycle();
        check_pred("addi", 1, 0, 0, 32'h304, 6'd1, 6'd1);
        set_upd(6'd3, 1'b1, 1'b0, 6'h3F);
        cycle();
        set_pred(32'h300, ADDI);
        cycle();
        check_pred("upd_no_mp", 1, 0, 0, 32'h304, 6'd1, 6'd1);

        // Recovery overrides the speculative shift of a same-cycle prediction
        do_reset();
        for (int k = 0; k < 3; k++) begin
            set_pred(32'h100, b_enc(16, 3'b000));
            cycle();
            check_pred("rec_pre", 1, 1, 0, 32'h104, 6'd0, 6'd0);
        end
        set_pred(32'h100, b_enc(16, 3'b000));
        set_upd(6'd20, 1'b1, 1'b1, 6'b000101);
        cycle();
        check_pred("rec_same", 1, 1, 0, 32'h104, 6'd0, 6'd0);
        set_pred(32'h100, b_enc(16, 3'b000));
        cycle();
        check_pred("rec_next", 1, 1, 0, 32'h104, 6'd11, 6'b001011);

        // Asynchronous reset mid-cycle clears outputs and counters
        do_reset();
        upd_n(2, 6'd7, 1'b1);
        set_pred(32'h1C, b_enc(16, 3'b000));
        cycle();
        check_pred("pre_arst", 1, 1, 1, 32'h2C, 6'd7, 6'd0);
        #2;
        rst_n_in = 1'b0;
        #1;
        check_pred("arst", 0, 0, 0, 32'h0, 6'd0, 6'd0);
        #1;
        rst_n_in = 1'b1;
        cycle();
        check_pred("post_arst", 0, 0, 0, 32'h0, 6'd0, 6'd0);
        set_pred(32'h1C, b_enc(16, 3'b000));
        cycle();
        check_pred("ctr_init", 1, 1, 0, 32'h20, 6'd7, 6'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
